// File: rtl/ads124x_spi_responder.sv
// ADS124x device-side SPI emulation: RDATA/RREG/WREG/RESET/NOP command handling,
// DRDY generation and a 24-bit sample feed from an AXI4-Stream slave.
module ads124x_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 15
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        SCK,
    input  logic        SS,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_T,
    input  logic        RESET_N,
    input  logic        START,
    output logic        DRDY
);
    localparam logic [2:0] ST_CMD    = 3'd0;
    localparam logic [2:0] ST_ARG    = 3'd1;
    localparam logic [2:0] ST_RDREG  = 3'd2;
    localparam logic [2:0] ST_WDATA  = 3'd3;
    localparam logic [2:0] ST_RDDATA = 3'd4;
    localparam logic [4:0] REG_LIMIT = 5'(NUM_REGS);

    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync, rstn_sync, start_sync;
    logic        sck_s, ss_s, mosi_s, rstn_s, start_s, sck_prev;
    logic        sck_rise, sck_fall, byte_done, addr_ok, in_read, beat_ok, rdata_cmd;
    logic [2:0]  state, bit_cnt;
    logic [6:0]  rx_shift;
    logic [7:0]  rx_byte, tx_shift, tx_next;
    logic [3:0]  addr;
    logic [4:0]  cnt;
    logic        is_write, drdy, tready, pend_valid;
    logic [1:0]  rd_idx;
    logic [23:0] data, pend;
    logic [7:0]  regs [NUM_REGS];
    logic        unused_tdata;

    assign unused_tdata = ^s_axis_tdata[31:24];

    always_ff @(posedge aclk) begin
        if (areset) begin
            sck_sync   <= '0;
            ss_sync    <= '1;
            mosi_sync  <= '0;
            rstn_sync  <= '1;
            start_sync <= '0;
            sck_prev   <= 1'b0;
            tready     <= 1'b0;
        end else begin
            sck_sync   <= {sck_sync[SYNC_STAGES-2:0], SCK};
            ss_sync    <= {ss_sync[SYNC_STAGES-2:0], SS};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            rstn_sync  <= {rstn_sync[SYNC_STAGES-2:0], RESET_N};
            start_sync <= {start_sync[SYNC_STAGES-2:0], START};
            sck_prev   <= sck_s;
            tready     <= 1'b1;
        end
    end

    assign sck_s   = sck_sync[SYNC_STAGES-1];
    assign ss_s    = ss_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign rstn_s  = rstn_sync[SYNC_STAGES-1];
    assign start_s = start_sync[SYNC_STAGES-1];

    assign sck_rise  = !ss_s && sck_s && !sck_prev;
    assign sck_fall  = !ss_s && !sck_s && sck_prev;
    assign byte_done = sck_fall && (bit_cnt == 3'd7);
    assign rx_byte   = {rx_shift, mosi_s};
    assign addr_ok   = {1'b0, addr} < REG_LIMIT;
    // A read counts as open until the synchronized SS rises, so pending samples land on that cycle.
    assign in_read   = (state == ST_RDDATA) && !ss_s;
    assign beat_ok   = s_axis_tvalid && start_s;
    assign rdata_cmd = byte_done && (state == ST_CMD) && (rx_byte[7:1] == 7'b0001001);

    always_comb begin
        tx_next = '0;
        case (state)
            ST_RDREG: if (addr_ok) tx_next = regs[addr];
            ST_RDDATA: begin
                case (rd_idx)
                    2'd0:    tx_next = data[23:16];
                    2'd1:    tx_next = data[15:8];
                    2'd2:    tx_next = data[7:0];
                    default: tx_next = '0;
                endcase
            end
            default: tx_next = '0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset || !rstn_s) begin
            state      <= ST_CMD;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            addr       <= '0;
            cnt        <= '0;
            is_write   <= 1'b0;
            rd_idx     <= '0;
            data       <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            drdy       <= 1'b1;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (ss_s) begin
                bit_cnt  <= '0;
                tx_shift <= '0;
                state    <= ST_CMD;
            end else begin
                if (sck_fall) begin
                    rx_shift <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (sck_rise) tx_shift <= (bit_cnt == 3'd0) ? tx_next : {tx_shift[6:0], 1'b0};
                if (byte_done) begin
                    case (state)
                        ST_CMD: begin
                            if (rx_byte[7:1] == 7'b0001001) begin
                                state  <= ST_RDDATA;
                                rd_idx <= '0;
                            end else if (rx_byte[7:4] == 4'h2 || rx_byte[7:4] == 4'h4) begin
                                state    <= ST_ARG;
                                addr     <= rx_byte[3:0];
                                is_write <= rx_byte[6];
                            end else if (rx_byte[7:1] == 7'b0000011) begin
                                drdy <= 1'b1;
                                for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
                            end
                        end
                        ST_ARG: begin
                            cnt   <= {1'b0, rx_byte[3:0]} + 5'd1;
                            state <= is_write ? ST_WDATA : ST_RDREG;
                        end
                        ST_RDREG, ST_WDATA: begin
                            if (state == ST_WDATA && addr_ok) regs[addr] <= rx_byte;
                            addr <= addr + 4'd1;
                            cnt  <= cnt - 5'd1;
                            if (cnt == 5'd1) state <= ST_CMD;
                        end
                        ST_RDDATA: if (rd_idx != 2'd3) rd_idx <= rd_idx + 2'd1;
                        default: state <= ST_CMD;
                    endcase
                end
            end

            // Sample handling follows the command decode so a sample beats a soft reset for DRDY.
            if (beat_ok) begin
                if (in_read) begin
                    pend       <= s_axis_tdata[23:0];
                    pend_valid <= 1'b1;
                end else begin
                    data       <= s_axis_tdata[23:0];
                    drdy       <= 1'b0;
                    pend_valid <= 1'b0;
                end
            end else if (pend_valid && !in_read) begin
                data       <= pend;
                drdy       <= 1'b0;
                pend_valid <= 1'b0;
            end
            if (rdata_cmd) drdy <= 1'b1;
        end
    end

    assign MISO          = tx_shift[7];
    assign MISO_T        = ss_s;
    assign DRDY          = drdy;
    assign s_axis_tready = tready;

endmodule

// File: tb/tb_ads124x_spi_responder.sv
// Randomized bench for ads124x_spi_responder: an SPI master drives transactions and
// results are compared with a register/sample model of the ADC.
module tb_ads124x_spi_responder;
    localparam int HALF = 8;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        SCK = 1'b0;
    logic        SS = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic        MISO_T;
    logic        RESET_N = 1'b1;
    logic        START = 1'b0;
    logic        DRDY;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    logic [7:0]  m_regs [16];
    logic [23:0] m_data;
    logic        m_drdy;
    logic [7:0]  wbuf [16];

    ads124x_spi_responder #(.SYNC_STAGES(2), .NUM_REGS(15)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .SCK(SCK), .SS(SS), .MOSI(MOSI), .MISO(MISO), .MISO_T(MISO_T),
        .RESET_N(RESET_N), .START(START), .DRDY(DRDY)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge aclk);
    endtask

    function automatic logic [7:0] m_rd(input int unsigned a);
        return (a < 15) ? m_regs[a] : 8'h00;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int unsigned nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i >= 8 - int'(nbits); i--) begin
            @(negedge aclk);
            SCK  = 1'b1;
            MOSI = tx[i];
            idle(HALF);
            rx[i] = MISO;
            SCK   = 1'b0;
            idle(HALF);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic ss_low();
        @(negedge aclk);
        SS = 1'b0;
        idle(HALF);
    endtask

    task automatic ss_high();
        idle(HALF);
        SS = 1'b1;
        idle(HALF);
    endtask

    task automatic do_wreg(input logic [3:0] a, input int unsigned n);
        logic [7:0] rx;
        ss_low();
        spi_byte({4'h4, a}, rx);
        spi_byte(8'(n - 1), rx);
        for (int unsigned k = 0; k < n; k++) begin
            spi_byte(wbuf[k], rx);
            if (((a + k) % 16) < 15) m_regs[(a + k) % 16] = wbuf[k];
        end
        ss_high();
    endtask

    task automatic do_rreg(input logic [3:0] a, input int unsigned n, input string tag);
        logic [7:0] rx;
        ss_low();
        spi_byte({4'h2, a}, rx);
        spi_byte(8'(n - 1), rx);
        for (int unsigned k = 0; k < n; k++) begin
            spi_byte(8'h00, rx);
            check($sformatf("%s[%0d]", tag, (a + k) % 16), {24'h0, rx}, {24'h0, m_rd((a + k) % 16)});
        end
        ss_high();
    endtask

    task automatic do_rdata(input string tag);
        logic [7:0] rx;
        ss_low();
        spi_byte(8'h12, rx);
        idle(4);
        check({tag, "_drdy_after_cmd"}, {31'h0, DRDY}, 32'h1);
        m_drdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            spi_byte(8'hFF, rx);
            check($sformatf("%s_b%0d", tag, k), {24'h0, rx},
                  (k == 3) ? 32'h0 : {24'h0, 8'(m_data >> (16 - 8 * k))});
        end
        ss_high();
    endtask

    task automatic push(input logic [31:0] v, input bit accepted);
        @(negedge aclk);
        check("tready", {31'h0, s_axis_tready}, 32'h1);
        s_axis_tdata  = v;
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        if (accepted) begin
            m_data = v[23:0];
            m_drdy = 1'b0;
        end
        idle(4);
    endtask

    logic [7:0]  rxb;
    int unsigned op, n;
    logic [3:0]  a;
    logic [31:0] v;

    initial begin
        model_clear();
        m_data = '0;
        m_drdy = 1'b1;

        idle(5);
        check("tready_in_reset", {31'h0, s_axis_tready}, 32'h0);
        areset = 1'b0;
        idle(4);
        check("reset_drdy", {31'h0, DRDY}, 32'h1);
        check("reset_miso_t", {31'h0, MISO_T}, 32'h1);
        check("reset_miso", {31'h0, MISO}, 32'h0);
        check("reset_tready", {31'h0, s_axis_tready}, 32'h1);
        do_rreg(4'h0, 15, "t1_regs");

        START = 1'b1;
        idle(4);
        push(32'h00ABCDEF, 1'b1);
        check("t2_drdy_before", {31'h0, DRDY}, 32'h0);
        do_rdata("t2_rdata");

        wbuf[0] = 8'h5A;
        wbuf[1] = 8'hC3;
        do_wreg(4'h2, 2);
        do_rreg(4'h2, 2, "t3_rd");
        wbuf[0] = 8'(($urandom & 8'hFE) | 8'h01);
        do_wreg(4'hE, 1);
        do_rreg(4'hE, 2, "t3_wrap");

        push(32'h55222222, 1'b1);
        ss_low();
        spi_byte(8'h12, rxb);
        m_drdy = 1'b1;
        spi_byte(8'h00, rxb);
        check("t4_b0", {24'h0, rxb}, 32'h22);
        push(32'h00111111, 1'b0);
        check("t4_drdy_open", {31'h0, DRDY}, 32'h1);
        spi_byte(8'h00, rxb);
        check("t4_b1", {24'h0, rxb}, 32'h22);
        spi_byte(8'h00, rxb);
        check("t4_b2", {24'h0, rxb}, 32'h22);
        idle(HALF);
        @(negedge aclk);
        SS = 1'b1;
        idle(2);
        check("t4_drdy_at_ss_rise", {31'h0, DRDY}, 32'h1);
        idle(1);
        check("t4_drdy_after_ss", {31'h0, DRDY}, 32'h0);
        m_data = 24'h111111;
        m_drdy = 1'b0;
        idle(HALF);
        do_rdata("t4_new");

        ss_low();
        spi_byte(8'h43, rxb);
        spi_byte(8'h00, rxb);
        spi_bits(8'hA5, 4, rxb);
        ss_high();
        do_rreg(4'h3, 1, "t5_unchanged");
        do_rreg(4'h2, 1, "t5_cmd_ok");

        for (int it = 0; it < 24; it++) begin
            op = $urandom_range(0, 2);
            a  = 4'($urandom_range(0, 15));
            n  = $urandom_range(1, 4);
            case (op)
                0: begin
                    for (int k = 0; k < 16; k++) wbuf[k] = 8'($urandom);
                    do_wreg(a, n);
                end
                1: do_rreg(a, n, "rnd_rreg");
                default: begin
                    v = $urandom;
                    push(v, 1'b1);
                    check("rnd_drdy", {31'h0, DRDY}, {31'h0, m_drdy});
                    do_rdata("rnd_rdata");
                end
            endcase
        end

        ss_low();
        spi_byte(8'h06, rxb);
        ss_high();
        model_clear();
        do_rreg(4'h0, 15, "t6_soft");

        for (int k = 0; k < 16; k++) wbuf[k] = 8'($urandom | 32'h1);
        do_wreg(4'h0, 4);
        push(32'h00123456, 1'b1);
        @(negedge aclk);
        RESET_N = 1'b0;
        idle(6);
        check("t6_tready_rstn", {31'h0, s_axis_tready}, 32'h1);
        check("t6_drdy_rstn", {31'h0, DRDY}, 32'h1);
        RESET_N = 1'b1;
        idle(6);
        model_clear();
        m_data = '0;
        m_drdy = 1'b1;
        do_rreg(4'h0, 4, "t6_pin");
        START = 1'b0;
        idle(4);
        push(32'h00777777, 1'b0);
        check("t6_start0_drdy", {31'h0, DRDY}, 32'h1);
        do_rdata("t6_data");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
